// File: rtl/mux_nto1_stream.sv
// N:1 valid/ready stream multiplexer with a registered output stage.
// Arbitration is round-robin, fixed-priority or externally selected.
module mux_nto1_stream #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  parameter int MODE   = 0,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_CH-1:0]       valid_i,
  input  logic [NUM_CH*WIDTH-1:0] data_i,
  output logic [NUM_CH-1:0]       ready_o,
  input  logic [SEL_W-1:0]        sel_i,
  output logic                    valid_o,
  output logic [WIDTH-1:0]        data_o,
  output logic [SEL_W-1:0]        grant_o,
  input  logic                    ready_i
);

  logic             load;
  logic             win_vld;
  logic [SEL_W-1:0] win;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_nxt;
  logic             xfer;
  logic             unused_sel;

  assign unused_sel = ^sel_i;

  assign load = !valid_o || ready_i;
  assign xfer = load && win_vld && !rst_i;

  // Round-robin: lowest offset from the pointer wins, so scan offsets
  // from high to low and let the last hit stand.
  function automatic logic [SEL_W:0] rr_pick(
    input logic [NUM_CH-1:0] v,
    input logic [SEL_W-1:0]  p
  );
    logic [SEL_W:0] res;
    int unsigned    j;
    res = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      j = (int'(p) + i) % NUM_CH;
      if (v[j]) res = {1'b1, SEL_W'(j)};
    end
    return res;
  endfunction

  function automatic logic [SEL_W:0] fp_pick(
    input logic [NUM_CH-1:0] v
  );
    logic [SEL_W:0] res;
    res = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) res = {1'b1, SEL_W'(i)};
    end
    return res;
  endfunction

  function automatic logic [SEL_W:0] es_pick(
    input logic [NUM_CH-1:0] v,
    input logic [SEL_W-1:0]  s
  );
    logic [SEL_W:0] res;
    res = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(s) == i && v[i]) res = {1'b1, SEL_W'(i)};
    end
    return res;
  endfunction

  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    if (MODE == 0) begin
      {win_vld, win} = rr_pick(valid_i, ptr);
    end else if (MODE == 1) begin
      {win_vld, win} = fp_pick(valid_i);
    end else begin
      {win_vld, win} = es_pick(valid_i, sel_i);
    end
  end

  always_comb begin
    ready_o = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!rst_i && load && win_vld && int'(win) == k) ready_o[k] = 1'b1;
    end
  end

  always_comb begin
    ptr_nxt = ptr;
    if (MODE == 0 && xfer) begin
      if (int'(win) == NUM_CH - 1) ptr_nxt = '0;
      else                         ptr_nxt = win + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      grant_o <= '0;
    end else if (load) begin
      valid_o <= win_vld;
      if (win_vld) begin
        data_o  <= data_i[int'(win)*WIDTH +: WIDTH];
        grant_o <= win;
      end
    end
  end

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Directed bench for mux_nto1_stream: one instance per arbitration mode
// sharing the same stimulus, each checked in its own section.
module tb_mux_nto1_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  valid;
  logic [31:0] data;
  logic [1:0]  sel;
  logic        rdy;

  logic [3:0] rr_ready, fp_ready, es_ready;
  logic       rr_valid, fp_valid, es_valid;
  logic [7:0] rr_data, fp_data, es_data;
  logic [1:0] rr_grant, fp_grant, es_grant;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mux_nto1_stream #(.NUM_CH(4), .WIDTH(8), .MODE(0)) u_rr (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .data_i(data),
    .ready_o(rr_ready), .sel_i(sel), .valid_o(rr_valid),
    .data_o(rr_data), .grant_o(rr_grant), .ready_i(rdy)
  );

  mux_nto1_stream #(.NUM_CH(4), .WIDTH(8), .MODE(1)) u_fp (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .data_i(data),
    .ready_o(fp_ready), .sel_i(sel), .valid_o(fp_valid),
    .data_o(fp_data), .grant_o(fp_grant), .ready_i(rdy)
  );

  mux_nto1_stream #(.NUM_CH(4), .WIDTH(8), .MODE(2)) u_es (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .data_i(data),
    .ready_o(es_ready), .sel_i(sel), .valid_o(es_valid),
    .data_o(es_data), .grant_o(es_grant), .ready_i(rdy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    valid = 4'hF;
    data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    sel   = 2'd0;
    rdy   = 1'b0;
    #2;
    chk("rst_valid", 32'(rr_valid), 32'd0);
    chk("rst_data",  32'(rr_data),  32'h0);
    chk("rst_grant", 32'(rr_grant), 32'd0);
    chk("rst_ready", 32'(rr_ready), 32'h0);

    // round-robin over four busy channels
    #10;
    rst = 1'b0;
    rdy = 1'b1;
    #1;
    chk("rr_ready0", 32'(rr_ready), 32'b0001);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("rr_data",  32'(rr_data),  32'(8'hA0 + i % 4));
      chk("rr_grant", 32'(rr_grant), 32'(i % 4));
      chk("rr_valid", 32'(rr_valid), 32'd1);
    end

    // backpressure holds word and pointer
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("bp_data",  32'(rr_data),  32'hA0);
      chk("bp_grant", 32'(rr_grant), 32'd0);
      chk("bp_valid", 32'(rr_valid), 32'd1);
      chk("bp_ready", 32'(rr_ready), 32'h0);
    end
    rdy = 1'b1;
    #1;
    chk("rel_ready", 32'(rr_ready), 32'b0010);
    tick;
    chk("rel_data",  32'(rr_data),  32'hA1);
    chk("rel_grant", 32'(rr_grant), 32'd1);

    // pointer wrap 3 -> 0
    valid = 4'b1000;
    #1;
    chk("wrap_ready3", 32'(rr_ready), 32'b1000);
    tick;
    chk("wrap_data3",  32'(rr_data),  32'hA3);
    chk("wrap_grant3", 32'(rr_grant), 32'd3);
    valid = 4'b1001;
    #1;
    chk("wrap_ready0", 32'(rr_ready), 32'b0001);
    tick;
    chk("wrap_data0",  32'(rr_data),  32'hA0);
    chk("wrap_grant0", 32'(rr_grant), 32'd0);
    #1;
    chk("wrap_ready3b", 32'(rr_ready), 32'b1000);
    tick;
    chk("wrap_grant3b", 32'(rr_grant), 32'd3);

    // asynchronous reset while stalled
    rdy = 1'b0;
    tick;
    chk("stall_valid", 32'(rr_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(rr_valid), 32'd0);
    chk("arst_data",  32'(rr_data),  32'h0);
    chk("arst_grant", 32'(rr_grant), 32'd0);
    chk("arst_ready", 32'(rr_ready), 32'h0);
    rst = 1'b0;

    // fixed priority starves ch3
    valid = 4'b1010;
    rdy   = 1'b1;
    #1;
    chk("fp_ready0", 32'(fp_ready), 32'b0010);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("fp_data",  32'(fp_data),  32'hA1);
      chk("fp_grant", 32'(fp_grant), 32'd1);
      chk("fp_ready", 32'(fp_ready), 32'b0010);
    end
    valid = 4'b1100;
    #1;
    chk("fp_ready2", 32'(fp_ready), 32'b0100);
    tick;
    chk("fp_data2",  32'(fp_data),  32'hA2);
    chk("fp_grant2", 32'(fp_grant), 32'd2);

    // external select
    sel   = 2'd2;
    valid = 4'b1011;
    #1;
    chk("es_ready_none", 32'(es_ready), 32'h0);
    tick;
    chk("es_valid_none", 32'(es_valid), 32'd0);
    sel  = 2'd1;
    data = {8'hA3, 8'hA2, 8'h5C, 8'hA0};
    #1;
    chk("es_ready1", 32'(es_ready), 32'b0010);
    tick;
    chk("es_data1",  32'(es_data),  32'h5C);
    chk("es_grant1", 32'(es_grant), 32'd1);
    chk("es_valid1", 32'(es_valid), 32'd1);
    rdy   = 1'b0;
    sel   = 2'd3;
    valid = 4'hF;
    tick;
    chk("es_hold_data",  32'(es_data),  32'h5C);
    chk("es_hold_grant", 32'(es_grant), 32'd1);
    chk("es_hold_ready", 32'(es_ready), 32'h0);
    rdy = 1'b1;
    #1;
    chk("es_ready3", 32'(es_ready), 32'b1000);
    tick;
    chk("es_data3",  32'(es_data),  32'hA3);
    chk("es_grant3", 32'(es_grant), 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
